multicycle_sequencer: RTL
=========================

// Module: multicycle_sequencer
// PURPOSE
// Multi-cycle control sequencer for the RV32I core. Latches the fetched instruction, maps it
// (plus branch-compare flags) to a 6-bit control-ROM address, captures the 20-bit control word
// and steps the datapath through FETCH/DECODE/EXEC/MEM/WB. Write strobes are gated per phase;
// illegal opcodes and memory timeouts halt the core in TRAP.
// PARAMETERS
// WIDTH_ADD   6    control-ROM address width
// WIDTH_DATA  20   control-word width
// TIMEOUT     16   max wait cycles on imem/dmem before bus trap (>=2)
// PORTS
// clk          in   1   clock, all state on rising edge
// rst          in   1   asynchronous, active-high reset
// instr        in   32  instruction from imem, valid when imem_ready=1
// imem_ready   in   1   imem data valid this cycle
// dmem_ready   in   1   dmem access complete this cycle
// br_eq        in   1   rs1==rs2, from regfile read of IR
// br_lt        in   1   rs1<rs2 signed
// br_ltu       in   1   rs1<rs2 unsigned
// ctrl_word    in   20  control ROM output for rom_addr
// rom_addr     out  6   control-ROM address (combinational from IR and br_*)
// ir           out  32  instruction register
// ctrl_q       out  20  latched control word, feeds datapath
// imem_req     out  1   instruction fetch request
// dmem_req     out  1   data access request
// mem_we       out  1   data write strobe (ctrl_q[7] gated to MEM)
// reg_we       out  1   regfile write strobe (ctrl_q[15] gated to WB)
// pc_we        out  1   PC update strobe; pc_sel=ctrl_q[19]
// trap         out  1   core halted
// trap_cause   out  2   00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
// instret      out  32  retired-instruction count
// BEHAVIOUR
// - Reset: state IDLE; ir, ctrl_q, instret, trap_cause = 0; all strobes 0. IDLE -> FETCH next edge.
// - Control word fields: [19]PCSel [18:16]ImmSel [15]RegWEn [14]BrUn [13]BSel [12]ASel
//   [11:8]ALUSel [7]MemRW [6:5]StSize [4:2]LdType [1:0]WBSel.
// - FETCH: imem_req=1. imem_ready=1 -> ir<=instr, go DECODE (same-cycle ready = 1-cycle fetch).
// - DECODE: rom_addr valid from ir+br_*; ctrl_q<=ctrl_word; illegal -> TRAP(01), else EXEC.
// - EXEC: 1 cycle. Load (ctrl_q[15]&WBSel==00) or store (ctrl_q[7]) -> MEM, else WB.
// - MEM: dmem_req=1, mem_we=ctrl_q[7]; dmem_ready=1 -> WB (load) / WB (store, reg_we stays 0).
// - WB: reg_we=ctrl_q[15], pc_we=1, instret+=1 (wraps at 2^32); next FETCH.
// - Latency with zero-wait memory: ALU/branch/jump/U = 4 cycles, load/store = 5.
// - Address map: R ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9; I ADDI10 SLTI11 SLTIU12
//   XORI13 ORI14 ANDI15 SLLI16 SRLI17 SRAI18; LB19 LH20 LW21 LBU22 LHU23; SB24 SH25 SW26;
//   branch base BEQ27 BNE29 BLT31 BGE33 BLTU35 BGEU37, +0 if flag (eq/lt/ltu) is 1, +1 if 0;
//   LUI39 AUIPC40 JAL41 JALR42. Unlisted opcode/funct3/funct7 combination = illegal.
// - Timeout: wait counter clears on entering FETCH/MEM, counts cycles with ready=0; when it
//   reaches TIMEOUT-1 with ready still 0 -> TRAP (10 fetch / 11 mem). Ready on that cycle wins.
// - TRAP: sticky until rst; all strobes 0, trap=1, ir/ctrl_q/instret frozen.
// - Reset mid-operation: strobes drop immediately (async), in-flight access abandoned.
// - Strobes are decoded from state register only: no glitch from ctrl_word changes.
// STRUCTURE
// - Package riscv_ctrl_pkg: state enum, control-word field bit positions, ROM address constants,
//   trap-cause codes, RV32I opcode constants.
// - Sub-module rom_addr_map (combinational ir+br_* -> rom_addr, illegal); FSM+counters in top.
// TESTING
// - ADD x3,x1,x2, zero-wait imem -> imem_req 1 cycle, rom_addr=0 in DECODE, reg_we+pc_we in cycle 4, instret=1.
// - BNE with br_eq=0 -> rom_addr=30, ctrl_q[19]=1, reg_we=0, pc_we=1; br_eq=1 -> rom_addr=29, ctrl_q[19]=0.
// - SW with dmem_ready delayed 3 cycles -> dmem_req & mem_we high 4 cycles in MEM, no reg_we, 8 cycles total.
// - Opcode 7'b0000000 -> trap=1, trap_cause=01 after DECODE; no strobes thereafter; rst clears.
// - imem_ready held 0 -> trap_cause=10 after exactly TIMEOUT FETCH cycles; ready on last cycle -> no trap.
// - rst asserted during MEM of LW -> dmem_req/reg_we drop asynchronously; restart IDLE->FETCH, instret=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  // Control-word field positions used by the sequencer itself
  localparam int unsigned REGWEN_BIT = 15;
  localparam int unsigned MEMRW_BIT  = 7;
  localparam int unsigned WBSEL_MSB  = 1;
  localparam int unsigned WBSEL_LSB  = 0;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM    = 2'b10;
  localparam logic [1:0] CAUSE_DMEM    = 2'b11;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Control-ROM entry points
  localparam logic [5:0] A_ADD   = 6'd0;
  localparam logic [5:0] A_SUB   = 6'd1;
  localparam logic [5:0] A_SLL   = 6'd2;
  localparam logic [5:0] A_SLT   = 6'd3;
  localparam logic [5:0] A_SLTU  = 6'd4;
  localparam logic [5:0] A_XOR   = 6'd5;
  localparam logic [5:0] A_SRL   = 6'd6;
  localparam logic [5:0] A_SRA   = 6'd7;
  localparam logic [5:0] A_OR    = 6'd8;
  localparam logic [5:0] A_AND   = 6'd9;
  localparam logic [5:0] A_ADDI  = 6'd10;
  localparam logic [5:0] A_SLTI  = 6'd11;
  localparam logic [5:0] A_SLTIU = 6'd12;
  localparam logic [5:0] A_XORI  = 6'd13;
  localparam logic [5:0] A_ORI   = 6'd14;
  localparam logic [5:0] A_ANDI  = 6'd15;
  localparam logic [5:0] A_SLLI  = 6'd16;
  localparam logic [5:0] A_SRLI  = 6'd17;
  localparam logic [5:0] A_SRAI  = 6'd18;
  localparam logic [5:0] A_LB    = 6'd19;
  localparam logic [5:0] A_LH    = 6'd20;
  localparam logic [5:0] A_LW    = 6'd21;
  localparam logic [5:0] A_LBU   = 6'd22;
  localparam logic [5:0] A_LHU   = 6'd23;
  localparam logic [5:0] A_SB    = 6'd24;
  localparam logic [5:0] A_SH    = 6'd25;
  localparam logic [5:0] A_SW    = 6'd26;
  localparam logic [5:0] A_BEQ   = 6'd27;
  localparam logic [5:0] A_BNE   = 6'd29;
  localparam logic [5:0] A_BLT   = 6'd31;
  localparam logic [5:0] A_BGE   = 6'd33;
  localparam logic [5:0] A_BLTU  = 6'd35;
  localparam logic [5:0] A_BGEU  = 6'd37;
  localparam logic [5:0] A_LUI   = 6'd39;
  localparam logic [5:0] A_AUIPC = 6'd40;
  localparam logic [5:0] A_JAL   = 6'd41;
  localparam logic [5:0] A_JALR  = 6'd42;

endpackage

// File: rtl/rom_addr_map.sv
// Maps the instruction register fields plus branch-compare flags to a control-ROM address.
module rom_addr_map
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_ADD = 6
) (
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 br_eq,
  input  logic                 br_lt,
  input  logic                 br_ltu,
  output logic [WIDTH_ADD-1:0] rom_addr,
  output logic                 illegal
);

  logic [5:0] addr;

  // Branch entries sit in pairs: base when the compare flag is set, base+1 when clear
  always_comb begin
    addr    = A_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'd0:    addr = A_ADD;
            3'd1:    addr = A_SLL;
            3'd2:    addr = A_SLT;
            3'd3:    addr = A_SLTU;
            3'd4:    addr = A_XOR;
            3'd5:    addr = A_SRL;
            3'd6:    addr = A_OR;
            default: addr = A_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          addr = A_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          addr = A_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        case (funct3)
          3'd0: addr = A_ADDI;
          3'd2: addr = A_SLTI;
          3'd3: addr = A_SLTIU;
          3'd4: addr = A_XORI;
          3'd6: addr = A_ORI;
          3'd7: addr = A_ANDI;
          3'd1: begin
            if (funct7 == F7_BASE) addr = A_SLLI;
            else                   illegal = 1'b1;
          end
          default: begin
            if (funct7 == F7_BASE)     addr = A_SRLI;
            else if (funct7 == F7_ALT) addr = A_SRAI;
            else                       illegal = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        case (funct3)
          3'd0:    addr = A_LB;
          3'd1:    addr = A_LH;
          3'd2:    addr = A_LW;
          3'd4:    addr = A_LBU;
          3'd5:    addr = A_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'd0:    addr = A_SB;
          3'd1:    addr = A_SH;
          3'd2:    addr = A_SW;
          default: illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (funct3)
          3'd0:    addr = A_BEQ  + {5'd0, ~br_eq};
          3'd1:    addr = A_BNE  + {5'd0, ~br_eq};
          3'd4:    addr = A_BLT  + {5'd0, ~br_lt};
          3'd5:    addr = A_BGE  + {5'd0, ~br_lt};
          3'd6:    addr = A_BLTU + {5'd0, ~br_ltu};
          3'd7:    addr = A_BGEU + {5'd0, ~br_ltu};
          default: illegal = 1'b1;
        endcase
      end
      OP_LUI:   addr = A_LUI;
      OP_AUIPC: addr = A_AUIPC;
      OP_JAL:   addr = A_JAL;
      OP_JALR: begin
        if (funct3 == 3'd0) addr = A_JALR;
        else                illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign rom_addr = WIDTH_ADD'(addr);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with bus timeouts and a sticky TRAP.
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_ADD  = 6,
  parameter int unsigned WIDTH_DATA = 20,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  br_eq,
  input  logic                  br_lt,
  input  logic                  br_ltu,
  input  logic [WIDTH_DATA-1:0] ctrl_word,
  output logic [WIDTH_ADD-1:0]  rom_addr,
  output logic [31:0]           ir,
  output logic [WIDTH_DATA-1:0] ctrl_q,
  output logic                  imem_req,
  output logic                  dmem_req,
  output logic                  mem_we,
  output logic                  reg_we,
  output logic                  pc_we,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [31:0]           instret
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             illegal;
  logic             is_mem;

  rom_addr_map #(
    .WIDTH_ADD (WIDTH_ADD)
  ) u_map (
    .opcode   (ir[6:0]),
    .funct3   (ir[14:12]),
    .funct7   (ir[31:25]),
    .br_eq    (br_eq),
    .br_lt    (br_lt),
    .br_ltu   (br_ltu),
    .rom_addr (rom_addr),
    .illegal  (illegal)
  );

  // Loads write back memory data (WBSel==00); stores are flagged by MemRW
  assign is_mem = (ctrl_q[REGWEN_BIT] && (ctrl_q[WBSEL_MSB:WBSEL_LSB] == 2'b00))
                || ctrl_q[MEMRW_BIT];

  // Strobes are set on the transition into their phase so they come straight from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      ir         <= '0;
      ctrl_q     <= '0;
      instret    <= '0;
      trap_cause <= CAUSE_NONE;
      trap       <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      mem_we     <= 1'b0;
      reg_we     <= 1'b0;
      pc_we      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          if (imem_ready) begin
            ir       <= instr;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else if (wait_cnt == CNT_LAST) begin
            imem_req   <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= CAUSE_IMEM;
            state      <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (illegal) begin
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
            state      <= S_TRAP;
          end else begin
            ctrl_q <= ctrl_word;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem) begin
            dmem_req <= 1'b1;
            mem_we   <= ctrl_q[MEMRW_BIT];
            wait_cnt <= '0;
            state    <= S_MEM;
          end else begin
            reg_we <= ctrl_q[REGWEN_BIT];
            pc_we  <= 1'b1;
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            mem_we   <= 1'b0;
            reg_we   <= ctrl_q[REGWEN_BIT];
            pc_we    <= 1'b1;
            state    <= S_WB;
          end else if (wait_cnt == CNT_LAST) begin
            dmem_req   <= 1'b0;
            mem_we     <= 1'b0;
            trap       <= 1'b1;
            trap_cause <= CAUSE_DMEM;
            state      <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          reg_we   <= 1'b0;
          pc_we    <= 1'b0;
          instret  <= instret + 32'd1;
          imem_req <= 1'b1;
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
